// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, fixed-latency port hold.
// Optional MAU_ERR_CNT_EN adds err_cnt_o, a saturating rejected-request count.
module mem_access_unit #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned ADDR_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
`ifdef MAU_ERR_CNT_EN
  output logic [7:0]  err_cnt_o,
`endif
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] WORDS  = 32'(ADDR_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        req_err;
  logic        last;

  assign req_err = (req_addr_i[1:0] != 2'b00) ||
                   ({2'b00, req_addr_i[31:2]} >= WORDS);
  assign last    = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = req_err ? RESP : ACCESS;
      ACCESS:  if (last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            wr_q  <= req_write_i;
            err_q <= req_err;
            // rejected requests leave the memory port untouched
            if (req_err) begin
              rdata_q <= 32'd0;
            end else begin
              addr_q  <= {2'b00, req_addr_i[31:2]};
              wdata_q <= req_wdata_i;
              cnt_q   <= LAT_M1;
            end
          end
        end
        ACCESS: begin
          if (last) begin
            rdata_q <= wr_q ? 32'd0 : mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAU_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_q <= 8'd0;
    end else if (state_q == RESP && err_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  // strobe decoded from state so reset drops it without a clock
  assign mem_write_o  = (state_q == ACCESS) && last && wr_q;
  assign req_ready_o  = (state_q == IDLE);
  assign stall_o      = (state_q != IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_err_o   = (state_q == RESP) && err_q;
  assign resp_rdata_o = rdata_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory port. Accepts one load/store request at a time from the MEM pipeline stage over a valid/ready handshake. Converts the byte address to a word index and drives the combinational data-memory port (address, write data, write strobe). Holds the port for a programmable number of cycles, then returns a registered read result. Rejects misaligned and out-of-range addresses without touching memory, and stalls the pipeline while busy.

Parameters:
LATENCY, 2, number of ACCESS cycles the memory port is held per request; legal range 1..15
ADDR_WORDS, 256, depth of the data memory in 32-bit words; word indices >= ADDR_WORDS are out of range

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
req_valid_i  input  1  request present
req_ready_o  output  1  unit can accept a request this cycle
req_write_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data
resp_valid_o  output  1  one-cycle response pulse
resp_rdata_o  output  32  load data; 0 for stores and errors
resp_err_o  output  1  qualifies resp_valid_o: request rejected (misaligned or out of range)
stall_o  output  1  pipeline hold; 1 whenever state != IDLE
mem_addr_o  output  32  word index to data memory
mem_wdata_o  output  32  write data to data memory
mem_write_o  output  1  write strobe to data memory
mem_rdata_i  input  32  combinational read data from data memory

Behaviour:
- Reset (rst_i=0, async): state=IDLE, counter=0, all registered outputs 0 (mem_addr_o, mem_wdata_o, mem_write_o, resp_valid_o, resp_rdata_o, resp_err_o). Any in-flight request is dropped, and mem_write_o falls immediately without waiting for a clock edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On the edge with req_valid_i=1, latch req_write_i, req_addr_i and req_wdata_i.
  - Error condition: req_addr_i[1:0]!=0 or req_addr_i[31:2]>=ADDR_WORDS. Go to RESP with err=1 and rdata=0; the memory port is not driven and mem_write_o stays 0.
  - Otherwise: load mem_addr_o = {2'b0, req_addr_i[31:2]} and mem_wdata_o = req_wdata_i, set counter = LATENCY-1, and go to ACCESS.
- ACCESS:
  - req_ready_o=0. mem_addr_o and mem_wdata_o are held stable.
  - Counter decrements each cycle.
  - mem_write_o=1 only in the final ACCESS cycle (counter==0) and only for stores, so there is exactly one write pulse per store.
  - In the final cycle, load requests capture mem_rdata_i into resp_rdata_o.
  - Next state is RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle; resp_err_o is valid with it.
  - Stores return resp_rdata_o=0.
  - req_ready_o=0. Next state is IDLE.
  - resp_rdata_o holds its value until the next response.
- Timing:
  - Request accepted at edge N: ACCESS spans cycles N+1..N+LATENCY, resp_valid_o is high in cycle N+LATENCY+1.
  - Error path: resp_valid_o is high in cycle N+1.
  - Peak throughput is one request per LATENCY+2 cycles.
- req_valid_i while not IDLE is ignored; the requester must hold the request until req_ready_o=1.
- stall_o = (state!=IDLE). It is combinational from the state register, and is 1 in the RESP cycle.
- mem_write_o is never 1 outside ACCESS.
- mem_addr_o and mem_wdata_o retain their last values in IDLE and RESP.
- The counter is 4 bits wide; LATENCY=1 means one ACCESS cycle.

Optional Feature:
MAU_ERR_CNT_EN
- Defined: adds output err_cnt_o [7:0], a count of rejected requests. It increments on each RESP cycle with resp_err_o=1, saturates at 255, and is cleared only by reset.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Store 0xDEADBEEF to byte address 0x10, LATENCY=2 -> mem_addr_o=4; mem_write_o high for exactly 1 cycle (cycle N+2); resp_valid_o in N+3 with err=0 and rdata=0; stall_o=1 for cycles N+1..N+3.
- Load from 0x10 after that store -> resp_rdata_o=0xDEADBEEF in cycle N+3; mem_write_o stays 0 throughout.
- Load from 0x13 (misaligned) and store to 0x400 (word index 256, out of range) -> each gives resp_valid_o in N+1 with resp_err_o=1 and rdata=0; memory contents unchanged; with MAU_ERR_CNT_EN, err_cnt_o=2.
- Assert rst_i=0 in the final ACCESS cycle of a store -> mem_write_o drops immediately; memory word not written; after release, state=IDLE, req_ready_o=1, all outputs 0.
- Back-to-back req_valid_i held high for stores to 0x0, 0x4, 0x8 -> three accepts spaced LATENCY+2 cycles apart; each address written once; no request lost or duplicated.
- LATENCY=1: load from 0x0 -> resp_valid_o in cycle N+2.
